rv32i_top: RTL and testbench

//  Single-cycle RV32I base-integer processor top: PC, instruction ROM, decoder/control,
//  32x32 register file, immediate generator, ALU, branch compare, byte-addressed data RAM.

---
 rtl/rv32i_top.sv | 189 ++++++++++++++++++
 tb/tb_rv32i_top.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rv32i_top.sv
// rtl/rv32i_top.sv - single-cycle RV32I core with instruction ROM and byte-lane data RAM
module rv32i_top #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter string       IMEM_FILE  = "program.mem",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4, WB_IMM} wb_sel_t;

  logic [31:0] rom  [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];

  logic [31:0] pc, next_pc, pc_plus4, instruction;
  logic [3:0]  ALUSel;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] data_out_1, data_out_2, ALU_data_out, main_mem_data_out, data_in;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_a, alu_b, load_data, st_data;
  logic [3:0]  be;
  logic        reg_we, mem_we, br_taken;
  wb_sel_t     wb_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  initial begin
    for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = '0;
  end

  assign instruction = rom[pc[IA+1:2]];
  assign pc_plus4    = pc + 32'd4;
  assign opcode      = instruction[6:0];
  assign rd_addr     = instruction[11:7];
  assign funct3      = instruction[14:12];
  assign rs1_addr    = instruction[19:15];
  assign rs2_addr    = instruction[24:20];
  assign funct7b5    = instruction[30];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  assign data_out_1 = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
  assign data_out_2 = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

  always_comb begin
    ALUSel = 4'b0000;
    alu_a  = data_out_1;
    alu_b  = data_out_2;
    reg_we = 1'b0;
    mem_we = 1'b0;
    wb_sel = WB_ALU;
    case (opcode)
      OP_LUI:    begin reg_we = 1'b1; wb_sel = WB_IMM; end
      OP_AUIPC:  begin alu_a = pc; alu_b = imm_u; reg_we = 1'b1; end
      OP_JAL:    begin alu_a = pc; alu_b = imm_j; reg_we = 1'b1; wb_sel = WB_PC4; end
      OP_JALR:   begin alu_b = imm_i; reg_we = 1'b1; wb_sel = WB_PC4; end
      OP_BRANCH: begin alu_a = pc; alu_b = imm_b; end
      OP_LOAD:   begin alu_b = imm_i; reg_we = 1'b1; wb_sel = WB_LOAD; end
      OP_STORE:  begin alu_b = imm_s; mem_we = 1'b1; end
      OP_IMM: begin
        alu_b  = imm_i;
        reg_we = 1'b1;
        // only shift-immediates carry funct7[5]; elsewhere bit 30 is immediate data
        ALUSel = (funct3 == 3'b001 || funct3 == 3'b101) ? {funct7b5, funct3} : {1'b0, funct3};
      end
      OP_REG:    begin reg_we = 1'b1; ALUSel = {funct7b5, funct3}; end
      default:   ;
    endcase
  end

  always_comb begin
    ALU_data_out = 32'd0;
    case (ALUSel[2:0])
      3'b000: ALU_data_out = ALUSel[3] ? alu_a - alu_b : alu_a + alu_b;
      3'b001: ALU_data_out = alu_a << alu_b[4:0];
      3'b010: ALU_data_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'b011: ALU_data_out = {31'd0, alu_a < alu_b};
      3'b100: ALU_data_out = alu_a ^ alu_b;
      3'b101: ALU_data_out = ALUSel[3] ? 32'($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
      3'b110: ALU_data_out = alu_a | alu_b;
      3'b111: ALU_data_out = alu_a & alu_b;
      default: ;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = data_out_1 == data_out_2;
      3'b001: br_taken = data_out_1 != data_out_2;
      3'b100: br_taken = $signed(data_out_1) <  $signed(data_out_2);
      3'b101: br_taken = $signed(data_out_1) >= $signed(data_out_2);
      3'b110: br_taken = data_out_1 <  data_out_2;
      3'b111: br_taken = data_out_1 >= data_out_2;
      default: ;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    case (opcode)
      OP_JAL:    next_pc = ALU_data_out;
      OP_JALR:   next_pc = ALU_data_out & ~32'd1;
      OP_BRANCH: if (br_taken) next_pc = ALU_data_out;
      default:   ;
    endcase
  end

  assign main_mem_data_out = dmem[ALU_data_out[DA+1:2]];

  always_comb begin
    ld_byte = main_mem_data_out[7:0];
    case (ALU_data_out[1:0])
      2'd1:    ld_byte = main_mem_data_out[15:8];
      2'd2:    ld_byte = main_mem_data_out[23:16];
      2'd3:    ld_byte = main_mem_data_out[31:24];
      default: ;
    endcase
    ld_half = ALU_data_out[1] ? main_mem_data_out[31:16] : main_mem_data_out[15:0];
    case (funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = main_mem_data_out;
    endcase
  end

  always_comb begin
    be      = 4'b1111;
    st_data = data_out_2;
    case (funct3[1:0])
      2'b00: begin be = 4'b0001 << ALU_data_out[1:0]; st_data = {4{data_out_2[7:0]}}; end
      2'b01: begin be = ALU_data_out[1] ? 4'b1100 : 4'b0011; st_data = {2{data_out_2[15:0]}}; end
      default: ;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_LOAD: data_in = load_data;
      WB_PC4:  data_in = pc_plus4;
      WB_IMM:  data_in = imm_u;
      default: data_in = ALU_data_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (reg_we && rd_addr != 5'd0) regs[rd_addr] <= data_in;
    end
  end

  // data RAM has no reset; rst only blocks stores while the core is held
  always_ff @(posedge clk) begin
    if (mem_we && rst)
      for (int k = 0; k < 4; k++)
        if (be[k]) dmem[ALU_data_out[DA+1:2]][8*k +: 8] <= st_data[8*k +: 8];
  end

endmodule

// File: tb/tb_rv32i_top.sv
// tb/tb_rv32i_top.sv - scoreboard bench: pc trace, register writebacks, final state
module tb_rv32i_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv32i_top #(.IMEM_FILE("")) dut (.clk(clk), .rst(rst));

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_pc_q[$];
  logic [36:0] exp_wb_q[$];
  logic [31:0] exp_regs[32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // rd of 0 means no architectural writeback is expected
  task automatic put(input logic [31:0] addr, input logic [31:0] ins,
                     input logic [4:0] rd, input logic [31:0] val);
    dut.rom[addr[9:2]] = ins;
    if (rd != 5'd0) begin
      exp_wb_q.push_back({rd, val});
      exp_regs[rd] = val;
    end
  endtask

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  initial begin
    logic [31:0] acc;
    logic [36:0] e;
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    for (int i = 0; i < 256; i++) dut.rom[i] = 32'h0000_0013;

    put(32'h00, enc_i(5, 0, 3'b000, 1, OPI), 1, 32'd5);
    put(32'h04, enc_i(-3, 0, 3'b000, 2, OPI), 2, 32'hFFFF_FFFD);
    put(32'h08, enc_r(7'h00, 2, 1, 3'b000, 3), 3, 32'd2);
    put(32'h0C, enc_r(7'h20, 2, 1, 3'b000, 4), 4, 32'd8);
    put(32'h10, enc_r(7'h00, 1, 2, 3'b010, 5), 5, 32'd1);
    put(32'h14, enc_i(-1, 0, 3'b000, 6, OPI), 6, 32'hFFFF_FFFF);
    put(32'h18, enc_s(0, 6, 0, 3'b010), 0, 0);
    put(32'h1C, enc_i(1, 0, 3'b000, 7, OPL), 7, 32'hFFFF_FFFF);
    put(32'h20, enc_i(1, 0, 3'b100, 8, OPL), 8, 32'h0000_00FF);
    put(32'h24, enc_s(2, 1, 0, 3'b000), 0, 0);
    put(32'h28, enc_i(2, 0, 3'b101, 9, OPL), 9, 32'h0000_FF05);
    put(32'h2C, enc_i(0, 0, 3'b010, 13, OPL), 13, 32'hFF05_FFFF);
    put(32'h30, enc_r(7'h00, 2, 1, 3'b011, 14), 14, 32'd1);
    put(32'h34, enc_i(32'h401, 2, 3'b101, 15, OPI), 15, 32'hFFFF_FFFE);
    put(32'h38, enc_i(28, 2, 3'b101, 16, OPI), 16, 32'h0000_000F);
    put(32'h3C, 32'h0000_0073, 0, 0);
    put(32'h40, enc_b(8, 1, 1, 3'b000), 0, 0);
    put(32'h44, enc_i(99, 0, 3'b000, 17, OPI), 0, 0);
    put(32'h48, enc_b(8, 1, 1, 3'b001), 0, 0);
    put(32'h4C, enc_i(2, 0, 3'b001, 18, OPL), 18, 32'hFFFF_FF05);
    put(32'h50, enc_j(16, 10), 10, 32'h0000_0054);
    put(32'h54, enc_i(1, 0, 3'b000, 17, OPI), 0, 0);
    put(32'h58, enc_i(1, 0, 3'b000, 17, OPI), 0, 0);
    put(32'h5C, enc_i(1, 0, 3'b000, 17, OPI), 0, 0);
    put(32'h60, enc_i(17, 10, 3'b000, 19, 7'b1100111), 19, 32'h0000_0064);
    put(32'h64, enc_b(8, 1, 2, 3'b100), 0, 0);
    put(32'h68, enc_i(2, 0, 3'b000, 17, OPI), 0, 0);
    put(32'h6C, {20'h12345, 5'd11, 7'b0110111}, 11, 32'h1234_5000);
    put(32'h70, {20'h00001, 5'd12, 7'b0010111}, 12, 32'h0000_1070);
    put(32'h74, enc_i(7, 0, 3'b000, 0, OPI), 0, 0);
    put(32'h78, enc_b(8, 1, 2, 3'b111), 0, 0);
    put(32'h7C, enc_i(3, 0, 3'b000, 17, OPI), 0, 0);
    put(32'h80, enc_j(0, 0), 0, 0);

    for (int a = 0; a <= 32'h40; a += 4) exp_pc_q.push_back(a);
    foreach (exp_pc_q[i]) ;
    exp_pc_q.push_back(32'h48); exp_pc_q.push_back(32'h4C); exp_pc_q.push_back(32'h50);
    exp_pc_q.push_back(32'h60); exp_pc_q.push_back(32'h64); exp_pc_q.push_back(32'h6C);
    exp_pc_q.push_back(32'h70); exp_pc_q.push_back(32'h74); exp_pc_q.push_back(32'h78);
    for (int i = 0; i < 6; i++) exp_pc_q.push_back(32'h80);

    repeat (2) begin
      @(negedge clk);
      check("rst_pc", dut.pc, 32'h0);
    end
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.regs[i];
    check("rst_regs", acc, 32'h0);

    #2 rst = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      check("pc", dut.pc, exp_pc_q.pop_front());
      if (dut.reg_we && dut.rd_addr != 5'd0) begin
        if (exp_wb_q.size() == 0) begin
          check("wb_extra_rd", {27'd0, dut.rd_addr}, 32'd0);
        end else begin
          e = exp_wb_q.pop_front();
          check("wb_rd", {27'd0, dut.rd_addr}, {27'd0, e[36:32]});
          check("wb_data", dut.data_in, e[31:0]);
        end
      end
    end
    check("wb_pending", exp_wb_q.size(), 32'd0);

    @(negedge clk);
    for (int i = 0; i < 32; i++) check($sformatf("x%0d", i), dut.regs[i], exp_regs[i]);
    check("mem0", dut.dmem[0], 32'hFF05_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
